chart_sequencer: RTL and testbench

- Drives the address of the combinational chart ROM (arrow pattern per step) and streams one pattern per step into the downstream note/scroll stage over a valid/ready handshake.
- Paces playback with an internal step timer, supports pause, and signals end of chart.
- Sits directly upstream of the chart ROM's address input and consumes its data output in the same cycle.

---
 rtl/ddr_pkg.sv | 14 +
 rtl/chart_sequencer_step_timer.sv | 38 +++
 rtl/chart_sequencer.sv | 102 ++++++++++
 tb/tb_chart_sequencer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ddr_pkg.sv
// Shared types and constants for the chart playback path.
package ddr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } chart_state_e;

  // 12 MHz clock / 8 steps per second
  localparam int unsigned default_step_cycles_c = 1500000;

endpackage

// File: rtl/chart_sequencer_step_timer.sv
// Chart step timer: counts to step_cycles_p-1, holds at terminal while hold_i,
// reloads to 0 when the terminal count is consumed.
module step_timer
  import ddr_pkg::*;
#(
  parameter int unsigned step_cycles_p = default_step_cycles_c
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic clear_i,
  input  logic en_i,
  input  logic hold_i,
  output logic tick_o
);

  localparam int unsigned tw_lp = $clog2(step_cycles_p);
  localparam logic [tw_lp-1:0] term_lp = tw_lp'(step_cycles_p - 1);

  logic [tw_lp-1:0] count_q;

  assign tick_o = (count_q == term_lp);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (en_i) begin
      if (!tick_o) begin
        count_q <= count_q + tw_lp'(1);
      end else if (!hold_i) begin
        count_q <= '0;
      end
    end
  end

endmodule

// File: rtl/chart_sequencer.sv
// Chart sequencer: addresses the chart ROM and streams one pattern per step
// over valid/ready. Define CHART_SEQUENCER_LOOP_EN to loop the chart forever.
module chart_sequencer
  import ddr_pkg::*;
#(
  parameter int unsigned width_p       = 8,
  parameter int unsigned depth_p       = 6,
  parameter int unsigned step_cycles_p = default_step_cycles_c
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic                       start_i,
  input  logic                       pause_i,
  output logic [$clog2(depth_p)-1:0] rd_addr_o,
  input  logic [width_p-1:0]         rd_data_i,
  output logic [width_p-1:0]         note_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic                       busy_o,
  output logic                       done_o
);

  localparam int unsigned aw_lp = $clog2(depth_p);
  localparam logic [aw_lp-1:0] last_lp = aw_lp'(depth_p - 1);

  chart_state_e state_q;
  logic         tick;
  logic         slot_free;
  logic         in_play;
  logic         start_ok;
  logic         emit;

  assign slot_free = !valid_o || ready_i;
  assign in_play   = (state_q == PLAY);
  assign start_ok  = start_i && ((state_q == IDLE) || (state_q == DONE));
  assign emit      = in_play && tick && !pause_i && slot_free;

  step_timer #(
    .step_cycles_p(step_cycles_p)
  ) u_step_timer (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .clear_i (start_ok),
    .en_i    (in_play && !pause_i),
    .hold_i  (!slot_free),
    .tick_o  (tick)
  );

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= IDLE;
      rd_addr_o <= '0;
      note_o    <= '0;
      valid_o   <= 1'b0;
    end else begin
      // A same-cycle emission overrides the handshake clear below.
      if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
      if (emit) begin
        note_o  <= rd_data_i;
        valid_o <= 1'b1;
      end

      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            state_q   <= PLAY;
            rd_addr_o <= '0;
          end
        end
        PLAY: begin
          if (emit) begin
            if (rd_addr_o == last_lp) begin
`ifdef CHART_SEQUENCER_LOOP_EN
              rd_addr_o <= '0;
`else
              state_q   <= DRAIN;
`endif
            end else begin
              rd_addr_o <= rd_addr_o + aw_lp'(1);
            end
          end
        end
        DRAIN: begin
          if (valid_o && ready_i) begin
            state_q <= DONE;
          end
        end
      endcase
    end
  end

  assign busy_o = (state_q == PLAY) || (state_q == DRAIN);

`ifdef CHART_SEQUENCER_LOOP_EN
  assign done_o = 1'b0;
`else
  assign done_o = (state_q == DONE);
`endif

endmodule

// File: tb/tb_chart_sequencer.sv
// Directed bench for chart_sequencer (step_cycles_p=4, depth_p=6).
// Cycle n below means "just after the n-th rising edge counted from the start_i edge".
module tb_chart_sequencer;

  localparam int W  = 8;
  localparam int D  = 6;
  localparam int S  = 4;
  localparam int AW = 3;

  logic          clk_i    = 1'b0;
  logic          reset_ni = 1'b0;
  logic          start_i  = 1'b0;
  logic          pause_i  = 1'b0;
  logic          ready_i  = 1'b1;
  logic [AW-1:0] rd_addr_o;
  logic [W-1:0]  rd_data_i;
  logic [W-1:0]  note_o;
  logic          valid_o;
  logic          busy_o;
  logic          done_o;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] exp_notes [D] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h00, 8'h0F};

  chart_sequencer #(
    .width_p      (W),
    .depth_p      (D),
    .step_cycles_p(S)
  ) dut (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .start_i  (start_i),
    .pause_i  (pause_i),
    .rd_addr_o(rd_addr_o),
    .rd_data_i(rd_data_i),
    .note_o   (note_o),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .busy_o   (busy_o),
    .done_o   (done_o)
  );

  // Chart ROM model
  always_comb begin
    rd_data_i = 8'h00;
    case (rd_addr_o)
      3'd0: rd_data_i = 8'h01;
      3'd1: rd_data_i = 8'h02;
      3'd2: rd_data_i = 8'h04;
      3'd3: rd_data_i = 8'h08;
      3'd4: rd_data_i = 8'h00;
      3'd5: rd_data_i = 8'h0F;
      default: rd_data_i = 8'h00;
    endcase
  end

  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timed out");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic play_entry(input int k);
    int exp_addr;
`ifdef CHART_SEQUENCER_LOOP_EN
    exp_addr = (k + 1) % D;
`else
    exp_addr = (k == D - 1) ? D - 1 : k + 1;
`endif
    for (int i = 0; i < S - 1; i++) begin
      step();
      chk($sformatf("gap_valid_%0d_%0d", k, i), 32'(valid_o), 32'd0);
    end
    step();
    chk($sformatf("emit_valid_%0d", k), 32'(valid_o), 32'd1);
    chk($sformatf("emit_note_%0d", k), 32'(note_o), 32'(exp_notes[k]));
    chk($sformatf("emit_addr_%0d", k), 32'(rd_addr_o), 32'(exp_addr));
  endtask

  task automatic do_start();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst_addr", 32'(rd_addr_o), 32'd0);
    chk("rst_note", 32'(note_o), 32'd0);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    #20 reset_ni = 1'b1;
    step();
    chk("idle_busy", 32'(busy_o), 32'd0);

    // Basic playback
    do_start();
    chk("play_busy", 32'(busy_o), 32'd1);
    for (int k = 0; k < D; k++) play_entry(k);

`ifdef CHART_SEQUENCER_LOOP_EN
    play_entry(0);
    chk("loop_busy", 32'(busy_o), 32'd1);
    chk("loop_done", 32'(done_o), 32'd0);
`else
    chk("drain_busy", 32'(busy_o), 32'd1);
    chk("drain_done", 32'(done_o), 32'd0);
    step();
    chk("done_done", 32'(done_o), 32'd1);
    chk("done_busy", 32'(busy_o), 32'd0);
    chk("done_valid", 32'(valid_o), 32'd0);
    chk("done_addr", 32'(rd_addr_o), 32'd5);
    step();
    step();
    chk("done_hold", 32'(done_o), 32'd1);

    // Restart from DONE, with a start_i during PLAY, backpressure and pause
    do_start();
    chk("rs_done", 32'(done_o), 32'd0);
    chk("rs_busy", 32'(busy_o), 32'd1);
    chk("rs_note", 32'(note_o), 32'h0F);
    chk("rs_valid", 32'(valid_o), 32'd0);
    chk("rs_addr", 32'(rd_addr_o), 32'd0);
    step();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk("ign_start_addr", 32'(rd_addr_o), 32'd0);
    chk("ign_start_valid", 32'(valid_o), 32'd0);
    step();
    chk("ign_start_c3", 32'(valid_o), 32'd0);
    step();
    chk("bp_c4_valid", 32'(valid_o), 32'd1);
    chk("bp_c4_note", 32'(note_o), 32'h01);
    ready_i = 1'b0;
    for (int c = 5; c <= 13; c++) begin
      step();
      chk($sformatf("bp_hold_valid_c%0d", c), 32'(valid_o), 32'd1);
      chk($sformatf("bp_hold_note_c%0d", c), 32'(note_o), 32'h01);
      chk($sformatf("bp_hold_addr_c%0d", c), 32'(rd_addr_o), 32'd1);
    end
    ready_i = 1'b1;
    step();
    chk("bp_c14_valid", 32'(valid_o), 32'd1);
    chk("bp_c14_note", 32'(note_o), 32'h02);
    chk("bp_c14_addr", 32'(rd_addr_o), 32'd2);
    step();
    chk("bp_c15_valid", 32'(valid_o), 32'd0);
    pause_i = 1'b1;
    for (int c = 16; c <= 18; c++) begin
      step();
      chk($sformatf("pause_valid_c%0d", c), 32'(valid_o), 32'd0);
    end
    pause_i = 1'b0;
    step();
    chk("pause_c19", 32'(valid_o), 32'd0);
    step();
    chk("pause_c20", 32'(valid_o), 32'd0);
    step();
    chk("pause_c21_valid", 32'(valid_o), 32'd1);
    chk("pause_c21_note", 32'(note_o), 32'h04);
    chk("pause_c21_addr", 32'(rd_addr_o), 32'd3);
    for (int k = 3; k < D; k++) play_entry(k);
    step();
    chk("rs_done_end", 32'(done_o), 32'd1);

    // Asynchronous reset mid-play, then replay from the first entry
    do_start();
    play_entry(0);
    play_entry(1);
    step();
    step();
    #2 reset_ni = 1'b0;
    #1;
    chk("arst_addr", 32'(rd_addr_o), 32'd0);
    chk("arst_note", 32'(note_o), 32'd0);
    chk("arst_valid", 32'(valid_o), 32'd0);
    chk("arst_busy", 32'(busy_o), 32'd0);
    chk("arst_done", 32'(done_o), 32'd0);
    #3 reset_ni = 1'b1;
    step();
    chk("arst_idle_busy", 32'(busy_o), 32'd0);
    do_start();
    chk("arst_restart_busy", 32'(busy_o), 32'd1);
    play_entry(0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
